// File: rtl/ahb_arbiter_if.sv
// AHB arbitration signal bundle: master requests and muxed bus status in, grant/ownership out.
interface ahb_arbiter_if;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] HSPLIT;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    input  HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Four-master round-robin AHB arbiter with burst/lock hold and SPLIT masking.
// Grant registered, one edge of latency; all state stalls while HREADY=0 (only HSPLIT unmasking proceeds).
module ahb_arbiter #(
  parameter int unsigned DEF_MST = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  ahb_arbiter_if.slave  bus
);

  localparam logic [1:0] L_DEF      = DEF_MST[1:0];
  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  logic [3:0] r_grant;
  logic [3:0] r_mask;
  logic [3:0] r_cnt;
  logic [1:0] r_master;
  logic       r_mastlock;

  logic [1:0] w_gidx;
  logic [1:0] w_pick;
  logic       w_found;
  logic       w_split;
  logic       w_hold;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_elig;
  logic [3:0] w_mask_nxt;

  always_comb begin
    w_gidx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r_grant[i]) w_gidx = 2'(i);
    end
  end

  assign w_split = bus.HREADY && (bus.HRESP == RESP_SPLIT);

  // Remaining-beat counter; any non-OKAY response abandons the burst.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (bus.HREADY) begin
      if (bus.HRESP != RESP_OKAY) begin
        w_cnt_nxt = 4'd0;
      end else begin
        case (bus.HTRANS)
          TR_IDLE: w_cnt_nxt = 4'd0;
          TR_NONSEQ: begin
            case (bus.HBURST)
              3'b010, 3'b011: w_cnt_nxt = 4'd3;
              3'b100, 3'b101: w_cnt_nxt = 4'd7;
              3'b110, 3'b111: w_cnt_nxt = 4'd15;
              default:        w_cnt_nxt = 4'd0;
            endcase
          end
          TR_SEQ:  if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
          default: w_cnt_nxt = r_cnt;
        endcase
      end
    end
  end

  // Holding while the counter stays above 1 lets the grant move with the last address phase.
  assign w_hold = !w_split && (bus.HLOCK[w_gidx] || (w_cnt_nxt > 4'd1));

  always_comb begin
    w_elig = bus.HBUSREQ & ~r_mask;
    if (w_split) w_elig[r_master] = 1'b0;
  end

  always_comb begin
    w_pick  = L_DEF;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && w_elig[w_gidx + 2'(k)]) begin
        w_pick  = w_gidx + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_mask_nxt = (r_mask | (w_split ? (4'b0001 << r_master) : 4'b0000)) & ~bus.HSPLIT;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_grant    <= 4'b0001 << L_DEF;
      r_master   <= L_DEF;
      r_mastlock <= 1'b0;
      r_mask     <= 4'b0000;
      r_cnt      <= 4'd0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_mask <= w_mask_nxt;
      if (bus.HREADY) begin
        r_master   <= w_gidx;
        r_mastlock <= bus.HLOCK[w_gidx];
        if (!w_hold) r_grant <= 4'b0001 << w_pick;
      end
    end
  end

  assign bus.HGRANT    = r_grant;
  assign bus.HMASTER   = r_master;
  assign bus.HMASTLOCK = r_mastlock;

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter DEF_MST, default 0: index (0..3) of the default master, granted when no eligible request exists.
REQ-002 HCLK  input  1  bus clock; all state updates on rising edge.
REQ-003 HRESET  input  1  synchronous reset, active-high, sampled on rising HCLK.
REQ-004 HBUSREQ  input  4  bus request, bit i from master i.
REQ-005 HLOCK  input  4  locked-transfer request, bit i from master i.
REQ-006 HTRANS  input  2  muxed bus transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-007 HBURST  input  3  muxed burst type: SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
REQ-008 HREADY  input  1  bus ready; transfer accepted when 1.
REQ-009 HRESP  input  2  slave response: OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
REQ-010 HSPLIT  input  4  split-resume strobe, bit i releases master i.
REQ-011 HGRANT  output  4  one-hot grant, registered.
REQ-012 HMASTER  output  2  index of master owning the current address phase, registered.
REQ-013 HMASTLOCK  output  1  current address phase is locked, registered.

Function
REQ-014 Eligible master: HBUSREQ[i]=1 and split-mask bit i=0.
REQ-015 Arbitration is round-robin: search starts at index (last granted + 1) mod 4, first eligible index wins.
REQ-016 No eligible master -> grant DEF_MST, including when DEF_MST is split-masked.
REQ-017 HGRANT updates only on a rising edge with HREADY=1 and arbitration not held (REQ-018..020); otherwise HGRANT holds.
REQ-018 Fixed-length burst hold: on accepted NONSEQ with HBURST WRAP4/INCR4, beat counter loads 3; WRAP8/INCR8 loads 7; WRAP16/INCR16 loads 15; SINGLE/INCR load 0.
REQ-019 Counter decrements by 1 on each accepted SEQ; arbitration held while counter > 1; grant may change on the edge accepting the beat that brings counter to 1 (handover aligned with last address phase).
REQ-020 Lock hold: while HLOCK[granted master]=1, arbitration held regardless of burst state.
REQ-021 Early burst termination: accepted IDLE or NONSEQ while counter > 0 overrides counter (IDLE clears it, NONSEQ reloads per REQ-018).
REQ-022 BUSY does not decrement the counter; INCR allows re-arbitration on any HREADY=1 edge.
REQ-023 HMASTER loads index of HGRANT on every rising edge with HREADY=1; HMASTLOCK loads HLOCK[granted master] on the same edge.
REQ-024 SPLIT: on edge with HRESP=SPLIT and HREADY=1, mask bit HMASTER set and arbitration forced free on that edge (lock and burst hold cleared).
REQ-025 RETRY: on edge with HRESP=RETRY and HREADY=1, burst counter cleared; no mask change; lock hold still applies.
REQ-026 ERROR: burst counter cleared; no mask change.
REQ-027 HSPLIT[i]=1 clears mask bit i on next edge; if SPLIT set and HSPLIT clear hit same bit same edge, clear wins.
REQ-028 HGRANT is always exactly one-hot.

Reset
REQ-029 On HRESET=1 at rising edge: HGRANT=1<<DEF_MST, HMASTER=DEF_MST, HMASTLOCK=0, split mask=0000, burst counter=0, round-robin pointer=DEF_MST.
REQ-030 Reset mid-burst or mid-lock abandons all hold state; first post-reset arbitration follows REQ-015 from the reset pointer.

Verification
REQ-031 Reset, no requests, HREADY=1 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 held indefinitely.
REQ-032 HBUSREQ=0101 constant, HTRANS=NONSEQ SINGLE, HREADY=1 -> HGRANT alternates 0100, 0001 each cycle; HMASTER follows one cycle later.
REQ-033 Master 0 granted, NONSEQ INCR4 then 3 SEQ, HBUSREQ=0011 -> HGRANT stays 0001 until edge accepting 3rd beat, then 0010.
REQ-034 Master 1 HLOCK=1 with HBUSREQ=1111 over 6 INCR transfers -> HGRANT=0010 and HMASTLOCK=1 throughout; grant moves to 0100 on first HREADY edge after HLOCK[1]=0.
REQ-035 Master 2 receives HRESP=SPLIT (HREADY 0 then 1), HBUSREQ=0100 -> grant to DEF_MST (0001); after HSPLIT=0100 one cycle, HGRANT=0100 on following HREADY edge.
REQ-036 HREADY=0 for 3 cycles with changing HBUSREQ -> HGRANT, HMASTER unchanged; HRESET=1 during INCR8 beat 4 -> outputs at reset values next edge.
